// File: rtl/bitsieve_update_responder.sv
// rtl/bitsieve_update_responder.sv - BitSieve datapath responder: winner latch, spin flip, E_off and local-field update
module bitsieve_update_responder #(
    parameter int N        = 16,
    parameter int IDX_W    = 4,
    parameter int H_W      = 16,
    parameter int W_W      = 8,
    parameter int EOFF_W   = 16,
    parameter int EOFF_INC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 latch_winner,
    input  logic [IDX_W-1:0]     winner_idx,
    input  logic                 winner_found,
    input  logic                 state_update_en,
    input  logic                 h_update_en,
    input  logic                 e_off_update_en,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [H_W-1:0]       load_data,
    output logic                 w_rd_en,
    output logic [IDX_W-1:0]     w_rd_addr,
    input  logic [N*W_W-1:0]     w_rd_data,
    output logic [N-1:0]         x_state,
    output logic [N*H_W-1:0]     h_flat,
    output logic [EOFF_W-1:0]    e_off,
    output logic [IDX_W-1:0]     win_idx_q,
    output logic                 upd_busy,
    output logic                 upd_done,
    output logic                 upd_overrun
);

    typedef enum logic [1:0] {IDLE, FETCH, APPLY} state_e;

    state_e                 state_q, state_d;
    logic                   win_vld_q;
    logic                   sign_q;
    logic [N-1:0]           x_state_q;
    logic [H_W-1:0]         h_q [N];
    logic [EOFF_W-1:0]      e_off_q;
    logic                   w_rd_en_q;
    logic [IDX_W-1:0]       w_rd_addr_q;
    logic                   upd_done_q;
    logic                   upd_overrun_q;
    logic                   start_upd;
    logic                   overrun_set;
    logic [EOFF_W:0]        e_off_sum;

    // h + (neg ? -2w : +2w) at H_W+2 bits, clamped to the signed H_W range.
    function automatic logic [H_W-1:0] sat_field(input logic [H_W-1:0] h,
                                                 input logic [W_W-1:0] w,
                                                 input logic neg);
        logic [H_W+1:0] h_ext;
        logic [H_W+1:0] w_dbl;
        logic [H_W+1:0] sum;
        h_ext = {{2{h[H_W-1]}}, h};
        w_dbl = {{(H_W+1-W_W){w[W_W-1]}}, w, 1'b0};
        sum   = neg ? (h_ext - w_dbl) : (h_ext + w_dbl);
        if (sum[H_W+1:H_W-1] == 3'b000 || sum[H_W+1:H_W-1] == 3'b111)
            return sum[H_W-1:0];
        else if (sum[H_W+1])
            return {1'b1, {(H_W-1){1'b0}}};
        else
            return {1'b0, {(H_W-1){1'b1}}};
    endfunction

    always_comb begin
        state_d     = state_q;
        start_upd   = 1'b0;
        overrun_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (h_update_en && win_vld_q) begin
                    start_upd = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                overrun_set = h_update_en || load_en;
                state_d     = APPLY;
            end
            APPLY: begin
                overrun_set = h_update_en || load_en;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign e_off_sum = {1'b0, e_off_q} + (EOFF_W+1)'(EOFF_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_idx_q     <= '0;
            win_vld_q     <= 1'b0;
            sign_q        <= 1'b0;
            x_state_q     <= '0;
            e_off_q       <= '0;
            w_rd_en_q     <= 1'b0;
            w_rd_addr_q   <= '0;
            upd_done_q    <= 1'b0;
            upd_overrun_q <= 1'b0;
        end else begin
            if (latch_winner) begin
                win_idx_q <= winner_idx;
                win_vld_q <= winner_found;
            end
            if (state_update_en && win_vld_q)
                x_state_q[win_idx_q] <= ~x_state_q[win_idx_q];
            if (e_off_update_en) begin
                if (win_vld_q)           e_off_q <= '0;
                else if (e_off_sum[EOFF_W]) e_off_q <= '1;
                else                     e_off_q <= e_off_sum[EOFF_W-1:0];
            end
            // Sign is sampled before any same-cycle flip takes effect.
            if (start_upd) begin
                sign_q      <= x_state_q[win_idx_q];
                w_rd_addr_q <= win_idx_q;
            end
            w_rd_en_q  <= start_upd;
            upd_done_q <= (state_q == APPLY);
            if (overrun_set) upd_overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) h_q[i] <= '0;
        end else if (state_q == APPLY) begin
            for (int i = 0; i < N; i++)
                h_q[i] <= sat_field(h_q[i], w_rd_data[i*W_W +: W_W], sign_q);
        end else if (state_q == IDLE && load_en) begin
            // Indices with no matching field are silently dropped.
            for (int i = 0; i < N; i++)
                if (load_idx == IDX_W'(i)) h_q[i] <= load_data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_hflat
        assign h_flat[g*H_W +: H_W] = h_q[g];
    end

    assign x_state     = x_state_q;
    assign e_off       = e_off_q;
    assign w_rd_en     = w_rd_en_q;
    assign w_rd_addr   = w_rd_addr_q;
    assign upd_busy    = (state_q != IDLE);
    assign upd_done    = upd_done_q;
    assign upd_overrun = upd_overrun_q;

endmodule

// File: tb/tb_bitsieve_update_responder.sv
// tb/tb_bitsieve_update_responder.sv - self-checking bench for bitsieve_update_responder
module tb_bitsieve_update_responder;
    localparam int N = 16, IDX_W = 4, H_W = 16, W_W = 8, EOFF_W = 16;
    localparam int EMAX = 65535;

    logic clk, rst_n;
    logic latch_winner, winner_found, state_update_en, h_update_en, e_off_update_en, load_en;
    logic [IDX_W-1:0] winner_idx, load_idx;
    logic [H_W-1:0] load_data;
    logic w_rd_en;
    logic [IDX_W-1:0] w_rd_addr;
    logic [N*W_W-1:0] w_rd_data;
    logic [N-1:0] x_state;
    logic [N*H_W-1:0] h_flat;
    logic [EOFF_W-1:0] e_off;
    logic [IDX_W-1:0] win_idx_q;
    logic upd_busy, upd_done, upd_overrun;

    bitsieve_update_responder #(.N(N), .IDX_W(IDX_W), .H_W(H_W), .W_W(W_W), .EOFF_W(EOFF_W), .EOFF_INC(1)) dut (
        .clk(clk), .rst_n(rst_n), .latch_winner(latch_winner), .winner_idx(winner_idx),
        .winner_found(winner_found), .state_update_en(state_update_en), .h_update_en(h_update_en),
        .e_off_update_en(e_off_update_en), .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data), .x_state(x_state),
        .h_flat(h_flat), .e_off(e_off), .win_idx_q(win_idx_q), .upd_busy(upd_busy),
        .upd_done(upd_done), .upd_overrun(upd_overrun));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memory: row returned one cycle after the read strobe.
    logic [W_W-1:0] wmem [N][N];
    always @(posedge clk)
        if (w_rd_en)
            for (int i = 0; i < N; i++) w_rd_data[i*W_W +: W_W] <= wmem[w_rd_addr][i];

    // Reference model state
    bit mx [N];
    int mh [N];
    int me, mwidx;
    bit mvld, mov;

    int n_checks = 0, n_fail = 0;

    typedef struct { int h0; int w; bit neg; int hexp; } sat_vec_t;
    sat_vec_t tbl [10];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint hget(input int i);
        logic signed [H_W-1:0] s;
        s = h_flat[i*H_W +: H_W];
        return longint'(s);
    endfunction

    function automatic int msat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int wv(input int j, input int i);
        logic signed [W_W-1:0] s;
        s = wmem[j][i];
        return int'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        latch_winner = 0; winner_idx = 0; winner_found = 0; state_update_en = 0;
        h_update_en = 0; e_off_update_en = 0; load_en = 0; load_idx = 0; load_data = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin mx[i] = 0; mh[i] = 0; end
        me = 0; mwidx = 0; mvld = 0; mov = 0;
    endtask

    task automatic model_flip_eoff(input bit flip, input bit eoff);
        if (eoff) me = mvld ? 0 : ((me + 1 > EMAX) ? EMAX : me + 1);
        if (flip && mvld) mx[mwidx] = !mx[mwidx];
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] ex;
        for (int i = 0; i < N; i++) ex[i] = mx[i];
        check({tag, " x_state"}, longint'(x_state), longint'(ex));
        for (int i = 0; i < N; i++) check($sformatf("%s h%0d", tag, i), hget(i), longint'(mh[i]));
        check({tag, " e_off"}, longint'(e_off), longint'(me));
        check({tag, " win_idx_q"}, longint'(win_idx_q), longint'(mwidx));
        check({tag, " busy"}, longint'(upd_busy), 0);
        check({tag, " overrun"}, longint'(upd_overrun), longint'(mov));
    endtask

    task automatic do_load(input int idx, input int v);
        load_en = 1; load_idx = IDX_W'(idx); load_data = H_W'(v);
        tick(); clear_inputs();
        mh[idx] = msat(v);
    endtask

    task automatic do_latch(input int idx, input bit found);
        latch_winner = 1; winner_idx = IDX_W'(idx); winner_found = found;
        tick(); clear_inputs();
        mwidx = idx; mvld = found;
    endtask

    task automatic do_strobe(input bit flip, input bit eoff);
        state_update_en = flip; e_off_update_en = eoff;
        tick(); clear_inputs();
        model_flip_eoff(flip, eoff);
    endtask

    // Full update transaction; inject adds a stray h_update_en + relatch in FETCH and a load in APPLY.
    task automatic do_update(input bit flip, input bit eoff, input bit inject, input string tag);
        int j, other;
        bit vld, sgn;
        j = mwidx; vld = mvld; sgn = mx[mwidx]; other = (mwidx + 5) % N;
        h_update_en = 1; state_update_en = flip; e_off_update_en = eoff;
        tick(); clear_inputs();
        model_flip_eoff(flip, eoff);
        if (vld) begin
            check({tag, " rd_en T+1"}, longint'(w_rd_en), 1);
            check({tag, " busy T+1"}, longint'(upd_busy), 1);
            check({tag, " rd_addr T+1"}, longint'(w_rd_addr), longint'(j));
            if (inject) begin
                h_update_en = 1; latch_winner = 1; winner_idx = IDX_W'(other); winner_found = 1;
            end
            tick(); clear_inputs();
            if (inject) begin mwidx = other; mvld = 1; mov = 1; end
            check({tag, " rd_en T+2"}, longint'(w_rd_en), 0);
            check({tag, " busy T+2"}, longint'(upd_busy), 1);
            check({tag, " rd_addr T+2"}, longint'(w_rd_addr), longint'(j));
            check({tag, " done T+2"}, longint'(upd_done), 0);
            if (inject) begin load_en = 1; load_idx = IDX_W'(j); load_data = 16'h1234; end
            tick(); clear_inputs();
            check({tag, " done T+3"}, longint'(upd_done), 1);
            check({tag, " rd_en T+3"}, longint'(w_rd_en), 0);
            for (int i = 0; i < N; i++) mh[i] = msat(mh[i] + (sgn ? -2 : 2) * wv(j, i));
        end else begin
            for (int c = 0; c < 3; c++) begin
                check({tag, " no rd_en"}, longint'(w_rd_en), 0);
                check({tag, " no busy"}, longint'(upd_busy), 0);
                tick();
            end
        end
        check_all(tag);
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        for (int j = 0; j < N; j++) for (int i = 0; i < N; i++) wmem[j][i] = '0;
        model_reset();
        tick(); tick();
        check("reset w_rd_en", longint'(w_rd_en), 0);
        check("reset w_rd_addr", longint'(w_rd_addr), 0);
        check("reset done", longint'(upd_done), 0);
        check("reset h_flat", longint'(h_flat == '0), 1);
        check_all("reset");
        rst_n = 1;
        tick();

        // Winner 3 with x3=0, row 3 all +5: flip, field update and E_off clear together
        for (int i = 0; i < N; i++) wmem[3][i] = 8'd5;
        do_load(3, 100);
        do_latch(3, 1);
        do_update(1, 1, 0, "tp_up");
        check("tp_up h3", hget(3), 110);
        check("tp_up x3", longint'(x_state[3]), 1);
        check("tp_up e_off", longint'(e_off), 0);
        do_update(1, 0, 0, "tp_down");
        check("tp_down h3", hget(3), 100);
        check("tp_down h0", hget(0), 0);
        check("tp_down x3", longint'(x_state[3]), 0);

        // Misses: E_off counts, state/h strobes are inert
        do_latch(3, 0);
        do_strobe(0, 1); do_strobe(0, 1); do_strobe(0, 1);
        check("miss e_off", longint'(e_off), 3);
        do_update(1, 0, 0, "miss_upd");

        // E_off saturation at the top of its range
        e_off_update_en = 1;
        repeat (EMAX - 1 - 3) tick();
        me = EMAX - 1;
        check("eoff 0xFFFE", longint'(e_off), longint'(me));
        tick(); me = EMAX;
        check("eoff 0xFFFF", longint'(e_off), 65535);
        tick(); tick();
        check("eoff hold", longint'(e_off), 65535);
        clear_inputs();

        // Saturation table: winner 2 drives field 5
        tbl[0] = '{h0: 100,    w: 5,    neg: 0, hexp: 110};
        tbl[1] = '{h0: 32760,  w: 7,    neg: 0, hexp: 32767};
        tbl[2] = '{h0: -32760, w: -7,   neg: 0, hexp: -32768};
        tbl[3] = '{h0: 32760,  w: -7,   neg: 1, hexp: 32767};
        tbl[4] = '{h0: -32760, w: 7,    neg: 1, hexp: -32768};
        tbl[5] = '{h0: 0,      w: -128, neg: 0, hexp: -256};
        tbl[6] = '{h0: 0,      w: -128, neg: 1, hexp: 256};
        tbl[7] = '{h0: 32767,  w: 0,    neg: 0, hexp: 32767};
        tbl[8] = '{h0: -100,   w: 127,  neg: 1, hexp: -354};
        tbl[9] = '{h0: 32753,  w: 7,    neg: 0, hexp: 32767};
        do_latch(2, 1);
        for (int k = 0; k < 10; k++) begin
            if (mx[2] != tbl[k].neg) do_strobe(1, 0);
            for (int i = 0; i < N; i++) wmem[2][i] = (i == 2) ? 8'd0 : W_W'($urandom_range(0, 255));
            wmem[2][5] = W_W'(tbl[k].w);
            do_load(5, tbl[k].h0);
            do_update(0, 0, 0, $sformatf("tbl%0d", k));
            check($sformatf("tbl%0d h5", k), hget(5), longint'(tbl[k].hexp));
        end

        // Overrun: stray start in FETCH, load in APPLY, relatch mid-flight
        do_latch(4, 1);
        do_update(0, 0, 1, "ovr");
        check("ovr flag", longint'(upd_overrun), 1);
        do_update(0, 0, 0, "ovr_after");

        // Randomized transactions against the model
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++) wmem[j][i] = (i == j) ? 8'd0 : W_W'($urandom_range(0, 255));
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0: do_load($urandom_range(0, N-1), int'($urandom_range(0, 65535)) - 32768);
                1: do_latch($urandom_range(0, N-1), ($urandom_range(0, 3) != 0));
                2: do_strobe($urandom_range(0, 1), $urandom_range(0, 1));
                default: do_update($urandom_range(0, 1), $urandom_range(0, 1), 0, $sformatf("rnd%0d", n));
            endcase
        end
        check_all("rnd_end");

        // Reset during APPLY
        do_latch(7, 1);
        do_load(1, 500);
        h_update_en = 1;
        tick(); clear_inputs();
        tick();
        check("rst pre busy", longint'(upd_busy), 1);
        rst_n = 0;
        #1;
        model_reset();
        check("rst w_rd_en", longint'(w_rd_en), 0);
        check("rst w_rd_addr", longint'(w_rd_addr), 0);
        check("rst done", longint'(upd_done), 0);
        check_all("rst_async");
        tick();
        rst_n = 1;
        tick(); tick();
        check("rst post done", longint'(upd_done), 0);
        check_all("rst_post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
